// File: rtl/lilme_host_sequencer.sv
// Host command sequencer for the LilME engine: stages operands, streams loads, captures result bursts.
// Optional watchdog abort in DRAIN/CAPTURE when LILME_SEQ_TIMEOUT_EN is defined.
module lilme_host_sequencer #(
    parameter int DW         = 32,
    parameter int OPND_DEPTH = 16,
    parameter int RES_DEPTH  = 8,
    parameter int BURST_LEN  = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic                          wr_en,
    input  logic [$clog2(OPND_DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]                 wr_data,
    input  logic [$clog2(RES_DEPTH)-1:0]  rd_addr,
    output logic [DW-1:0]                 rd_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [2:0]                    me_opcode,
    output logic                          me_a_op,
    output logic                          me_b_op,
    output logic [DW-1:0]                 me_data,
    input  logic                          me_busy,
    input  logic [DW-1:0]                 me_dout,
    input  logic                          me_dout_valid
);
    localparam int AW = $clog2(OPND_DEPTH);
    localparam int RW = $clog2(RES_DEPTH);
    localparam int CW = $clog2(BURST_LEN);

    typedef enum logic [2:0] {IDLE, ISSUE, STREAM, DRAIN, CAPTURE} state_t;

    state_t          state;
    logic [1:0]      op;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   idx_nxt;
    logic [CW-1:0]   cap_cnt;
    logic [DW-1:0]   opnd [OPND_DEPTH];
    logic [DW-1:0]   res  [RES_DEPTH];
    logic            cap_we;

    function automatic logic [2:0] op_code(input logic [1:0] c);
        case (c)
            2'b00:   op_code = 3'b010;
            2'b01:   op_code = 3'b011;
            2'b10:   op_code = 3'b101;
            default: op_code = 3'b111;
        endcase
    endfunction

    assign idx_nxt = idx + 1'b1;
    assign cap_we  = (state == CAPTURE) && me_dout_valid;
    assign rd_data = res[rd_addr];

    // Storage is intentionally not reset; partial captures survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en && state != STREAM)
            opnd[wr_addr] <= wr_data;
        if (cap_we)
            res[cap_cnt[RW-1:0]] <= me_dout;
    end

`ifdef LILME_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op        <= 2'b00;
            idx       <= '0;
            cap_cnt   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            me_opcode <= 3'b000;
            me_a_op   <= 1'b0;
            me_b_op   <= 1'b0;
            me_data   <= '0;
`ifdef LILME_SEQ_TIMEOUT_EN
            wd        <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op        <= cmd_op;
                        me_opcode <= op_code(cmd_op);
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    me_opcode <= 3'b000;
                    if (!op[1]) begin
                        idx     <= '0;
                        me_data <= opnd[0];
                        me_a_op <= ~op[0];
                        me_b_op <= op[0];
                        state   <= STREAM;
                    end else begin
                        cap_cnt <= '0;
                        state   <= CAPTURE;
                    end
                end
                STREAM: begin
                    if (idx == AW'(OPND_DEPTH - 1)) begin
                        me_a_op <= 1'b0;
                        me_b_op <= 1'b0;
                        me_data <= '0;
                        // An idle engine lets us skip DRAIN entirely.
                        if (!me_busy) begin
                            state <= IDLE; done <= 1'b1; cmd_ready <= 1'b1; busy <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        idx     <= idx_nxt;
                        me_data <= opnd[idx_nxt];
                    end
                end
                DRAIN: begin
                    if (!me_busy) begin
                        state <= IDLE; done <= 1'b1; cmd_ready <= 1'b1; busy <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (me_dout_valid) begin
                        cap_cnt <= cap_cnt + 1'b1;
                        if (cap_cnt == CW'(BURST_LEN - 1)) begin
                            if (!me_busy) begin
                                state <= IDLE; done <= 1'b1; cmd_ready <= 1'b1; busy <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef LILME_SEQ_TIMEOUT_EN
            if ((state != DRAIN && state != CAPTURE) || cap_we) begin
                wd <= '0;
            end else if (wd == WW'(TIMEOUT - 1) && !(state == DRAIN && !me_busy)) begin
                wd        <= '0;
                state     <= IDLE;
                err       <= 1'b1;
                done      <= 1'b0;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                me_opcode <= 3'b000;
                me_a_op   <= 1'b0;
                me_b_op   <= 1'b0;
                me_data   <= '0;
            end else begin
                wd <= wd + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_lilme_host_sequencer.sv
// Scoreboard bench for lilme_host_sequencer: expected opcodes/stream words queued at issue,
// popped by a negedge monitor; result buffer checked against a small model.
module tb_lilme_host_sequencer;
    localparam int DW = 32;
    localparam int OD = 16;
    localparam int RD = 8;
    localparam int BL = 64;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy, done, err;
    logic [2:0]    me_opcode;
    logic          me_a_op, me_b_op;
    logic [DW-1:0] me_data;
    logic          me_busy;
    logic [DW-1:0] me_dout;
    logic          me_dout_valid;

    lilme_host_sequencer #(.DW(DW), .OPND_DEPTH(OD), .RES_DEPTH(RD), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .me_opcode(me_opcode), .me_a_op(me_a_op),
        .me_b_op(me_b_op), .me_data(me_data), .me_busy(me_busy), .me_dout(me_dout),
        .me_dout_valid(me_dout_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0, last_done_cyc = 0;
    int err_cnt = 0, last_err_cyc = 0;

    logic [2:0]    exp_op[$];
    logic [DW+1:0] exp_word[$];
    logic [DW-1:0] opnd_m[OD];
    logic [DW-1:0] res_m[RD];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (me_opcode != 3'b000) begin
                if (exp_op.size() == 0) check("opcode_extra", 64'(me_opcode), 64'd0);
                else check("opcode", 64'(me_opcode), 64'(exp_op.pop_front()));
            end
            if (me_a_op || me_b_op) begin
                if (exp_word.size() == 0) check("stream_extra", 64'({me_a_op, me_b_op, me_data}), 64'd0);
                else check("stream_word", 64'({me_a_op, me_b_op, me_data}), 64'(exp_word.pop_front()));
            end
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (err)  begin err_cnt++;  last_err_cyc  = cyc; end
        end
    end

    function automatic logic [2:0] exp_code(input logic [1:0] c);
        case (c)
            2'b00:   return 3'b010;
            2'b01:   return 3'b011;
            2'b10:   return 3'b101;
            default: return 3'b111;
        endcase
    endfunction

    task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op);
        check("cmd_ready_before", 64'(cmd_ready), 64'd1);
        exp_op.push_back(exp_code(op));
        if (!op[1])
            for (int i = 0; i < OD; i++) exp_word.push_back({~op[0], op[0], opnd_m[i]});
        cmd_valid = 1'b1; cmd_op = op;
        @(posedge clk); #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int exp_lat, input string tag);
        int start, n;
        start = done_cnt; n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if (done_cnt == start) begin
            check({tag, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(last_done_cyc - acc_cyc + 1), 64'(exp_lat));
            check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
            check({tag, "_busy"}, 64'(busy), 64'd0);
        end
        check({tag, "_sb_empty"}, 64'(exp_word.size() + exp_op.size()), 64'd0);
    endtask

    task automatic run_capture(input logic [DW-1:0] base, input bit gaps, input bit same_slot,
                               output int jlast);
        int k, j;
        k = 0; j = 0; jlast = 0;
        while (k < BL) begin
            if (!gaps || (j % 2 == 0)) begin
                me_dout_valid = 1'b1; me_dout = base + DW'(k);
                if (same_slot && k == 10) begin
                    rd_addr = 3'(k % RD); #1;
                    check("rd_same_cycle_old", 64'(rd_data), 64'(res_m[k % RD]));
                end
                res_m[k % RD] = base + DW'(k);
                jlast = j; k++;
            end else begin
                me_dout_valid = 1'b0; me_dout = $urandom;
            end
            @(posedge clk); #1;
            j++;
        end
        me_dout_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int jl, d0, e0, n;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; rd_addr = '0; me_busy = 1'b0; me_dout = '0; me_dout_valid = 1'b0;
        #2;
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_outs", 64'({busy, done, err, me_opcode, me_a_op, me_b_op}), 64'd0);
        check("rst_data", 64'(me_data), 64'd0);
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;

        // LOAD_A with engine busy after streaming
        for (int i = 0; i < OD; i++) begin opnd_m[i] = DW'(i + 1); wr(4'(i), DW'(i + 1)); end
        me_busy = 1'b1;
        d0 = done_cnt;
        issue(2'b00);
        repeat (20) @(posedge clk); #1;
        check("t1_no_done_while_busy", 64'(done_cnt), 64'(d0));
        check("t1_busy_drain", 64'(busy), 64'd1);
        me_busy = 1'b0;
        wait_done(10, 22, "t1");

        // LOAD_B with a write during STREAM that must be dropped
        issue(2'b01);
        repeat (4) @(posedge clk); #1;
        wr(4'd0, 32'hDEAD_BEEF);
        wait_done(30, 18, "t2");
        // back-to-back: accept in the done cycle, stream shows opnd[0] intact
        issue(2'b00);
        wait_done(30, 18, "t3_b2b");

        // MULTIPLY, contiguous burst; stray valid during ISSUE must be ignored
        issue(2'b10);
        me_dout_valid = 1'b1; me_dout = 32'd999;
        @(posedge clk); #1;
        run_capture(32'd100, 1'b0, 1'b0, jl);
        wait_done(10, jl + 3, "t4_mul");
        for (int k = 0; k < RD; k++) begin
            rd_addr = 3'(k); #1;
            check("t4_slot", 64'(rd_data), 64'(156 + k));
        end

        // READ with gaps every other cycle
        @(posedge clk); #1;
        issue(2'b11);
        @(posedge clk); #1;
        run_capture(32'hA000_0000, 1'b1, 1'b1, jl);
        wait_done(10, jl + 3, "t5_read");
        for (int k = 0; k < RD; k++) begin
            rd_addr = 3'(k); #1;
            check("t5_slot", 64'(rd_data), 64'(32'hA000_0000 + 32'(BL - RD + k)));
        end

        // async reset during STREAM at word 5
        @(posedge clk); #1;
        issue(2'b00);
        repeat (6) @(posedge clk); #1;
        check("t6_word5", 64'({me_a_op, me_data}), 64'({1'b1, opnd_m[5]}));
        reset = 1'b1; #1;
        check("t6_rst_ready", 64'(cmd_ready), 64'd1);
        check("t6_rst_outs", 64'({busy, done, err, me_opcode, me_a_op, me_b_op}), 64'd0);
        check("t6_rst_data", 64'(me_data), 64'd0);
        exp_word.delete(); exp_op.delete();
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(2'b00);
        wait_done(30, 18, "t6_restart");

        // engine stuck busy after a load
        @(posedge clk); #1;
        me_busy = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        issue(2'b00);
`ifdef LILME_SEQ_TIMEOUT_EN
        n = 0;
        while (err_cnt == e0 && n < 80) begin @(negedge clk); #1; n++; end
        check("t7_err_seen", 64'(err_cnt - e0), 64'd1);
        check("t7_err_latency", 64'(last_err_cyc - acc_cyc + 1), 64'(OD + 2 + TO));
        check("t7_no_done", 64'(done_cnt), 64'(d0));
        check("t7_ready", 64'({cmd_ready, busy, me_a_op, me_b_op}), 64'b1000);
        @(negedge clk); #1;
        check("t7_err_pulse", 64'(err), 64'd0);
        me_busy = 1'b0;
`else
        repeat (60) @(posedge clk); #1;
        check("t7_no_err", 64'(err_cnt), 64'(e0));
        check("t7_no_done", 64'(done_cnt), 64'(d0));
        check("t7_still_busy", 64'(busy), 64'd1);
        me_busy = 1'b0;
        n = 0;
        wait_done(5, 62, "t7_late_done");
`endif
        check("final_sb_empty", 64'(exp_word.size() + exp_op.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
